// File: rtl/rr_arb_if.sv
// Request/grant bundle for the round-robin arbiter.
// The arbiter sits on the slave side. The requesting logic or the bench uses the master side.
interface rr_arb_if #(
  parameter int W = 4
) ();
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]  i_req;
  logic          i_en;
  logic          i_ack;
  logic          o_gnt_vld;
  logic [W-1:0]  o_gnt;
  logic [IW-1:0] o_gnt_idx;

  modport master (
    output i_req, i_en, i_ack,
    input  o_gnt_vld, o_gnt, o_gnt_idx
  );

  modport slave (
    input  i_req, i_en, i_ack,
    output o_gnt_vld, o_gnt, o_gnt_idx
  );
endinterface

// File: rtl/rr_arb.sv
// Registered round-robin arbiter with hold/ack handshake. The grant is sticky
// until acked, and only an accepted grant advances the rotation pointer.
module rr_arb #(
  parameter int W           = 4,
  parameter int TOWARDS_LSB = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb_if.slave    bus
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;
  // After reset the pointer sits on the last position, so the first winner is index 0 (MSB mode) or W-1 (LSB mode).
  localparam logic [W-1:0] PTR_RST = (TOWARDS_LSB != 0) ? W'(1) : (W'(1) << (W - 1));

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   ptr_eff, msk, req_msk, winner;
  logic           can_arb;

  // Exclusive unary mask: positions strictly past the pointer in the rotation direction.
  function automatic logic [W-1:0] excl_mask(input logic [W-1:0] p);
    logic [W-1:0] m;
    logic         seen;
    m    = '0;
    seen = 1'b0;
    if (TOWARDS_LSB == 0) begin
      for (int i = 0; i < W; i++) begin
        m[i] = seen;
        seen = seen | p[i];
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        m[i] = seen;
        seen = seen | p[i];
      end
    end
    return m;
  endfunction

  // Nearest set bit in the rotation direction: the lowest bit in MSB mode, the highest bit in LSB mode.
  function automatic logic [W-1:0] pick_first(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         found;
    r     = '0;
    found = 1'b0;
    if (TOWARDS_LSB == 0) begin
      for (int i = 0; i < W; i++) begin
        r[i]  = v[i] & ~found;
        found = found | v[i];
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        r[i]  = v[i] & ~found;
        found = found | v[i];
      end
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] encode(input logic [W-1:0] oh);
    logic [IW-1:0] b;
    b = '0;
    for (int i = 0; i < W; i++) begin
      b = b | (oh[i] ? IW'(i) : {IW{1'b0}});
    end
    return b;
  endfunction

  // Next-state, pointer and grant selection
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    can_arb = bus.i_en && (|bus.i_req);
    ptr_eff = ((state_q == GRANT) && bus.i_ack) ? gnt_q : ptr_q;
    msk     = excl_mask(ptr_eff);
    req_msk = bus.i_req & msk;
    winner  = (|req_msk) ? pick_first(req_msk) : pick_first(bus.i_req);
    case (state_q)
      IDLE: begin
        if (can_arb) begin
          state_d = GRANT;
          gnt_d   = winner;
          idx_d   = encode(winner);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (bus.i_ack) begin
          ptr_d = gnt_q;
          if (can_arb) begin
            gnt_d = winner;
            idx_d = encode(winner);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State, pointer and grant registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      gnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.o_gnt_vld = (state_q == GRANT);
  assign bus.o_gnt     = gnt_q;
  assign bus.o_gnt_idx = idx_q;
endmodule

// File: tb/tb_rr_arb.sv
// Directed and random bench for rr_arb. It uses a scoreboard queue of expected grants,
// and a checker module holds the protocol properties.
module rr_arb_chk #(
  parameter int W = 4
) (
  input logic         clk,
  input logic         rst_n,
  input logic         ack,
  input logic         vld,
  input logic [W-1:0] gnt
);
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_vld:    assert property (@(posedge clk) disable iff (!rst_n) vld == (|gnt));
  a_stable: assert property (@(posedge clk) disable iff (!rst_n) (vld && !ack) |=> $stable(gnt));
endmodule

module tb_rr_arb;
  logic clk;
  logic rst_n;
  int   n_asserts;
  int   n_fails;
  int   wait_n;
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];
  logic [3:0] r_req;
  logic       r_en;
  logic       r_ack;

  rr_arb_if #(.W(4)) if_a ();
  rr_arb_if #(.W(4)) if_b ();

  rr_arb #(.W(4), .TOWARDS_LSB(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  rr_arb #(.W(4), .TOWARDS_LSB(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  rr_arb_chk #(.W(4)) u_chk_a (.clk(clk), .rst_n(rst_n), .ack(if_a.i_ack),
                               .vld(if_a.o_gnt_vld), .gnt(if_a.o_gnt));
  rr_arb_chk #(.W(4)) u_chk_b (.clk(clk), .rst_n(rst_n), .ack(if_b.i_ack),
                               .vld(if_b.o_gnt_vld), .gnt(if_b.o_gnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] b;
    b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) b = 2'(i);
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [3:0] exp_gnt);
    logic [6:0] exp_v;
    exp_v = {(|exp_gnt), exp_gnt, idx_of(exp_gnt)};
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s observed vld/gnt/idx=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step_a(input string tag, input logic [3:0] req, input logic en,
                        input logic ack, input logic [3:0] exp_gnt);
    if_a.i_req = req;
    if_a.i_en  = en;
    if_a.i_ack = ack;
    q_a.push_back(exp_gnt);
    @(posedge clk);
    #1;
    chk(tag, {if_a.o_gnt_vld, if_a.o_gnt, if_a.o_gnt_idx}, q_a.pop_front());
  endtask

  task automatic step_b(input string tag, input logic [3:0] req, input logic en,
                        input logic ack, input logic [3:0] exp_gnt);
    if_b.i_req = req;
    if_b.i_en  = en;
    if_b.i_ack = ack;
    q_b.push_back(exp_gnt);
    @(posedge clk);
    #1;
    chk(tag, {if_b.o_gnt_vld, if_b.o_gnt, if_b.o_gnt_idx}, q_b.pop_front());
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    wait_n    = 0;
    rst_n     = 1'b0;
    if_a.i_req = 4'b0000; if_a.i_en = 1'b0; if_a.i_ack = 1'b0;
    if_b.i_req = 4'b0000; if_b.i_en = 1'b0; if_b.i_ack = 1'b0;

    step_a("reset", 4'b0000, 1'b0, 1'b0, 4'b0000);
    step_a("reset", 4'b1111, 1'b1, 1'b1, 4'b0000);
    rst_n = 1'b1;

    // full rotation with ack every cycle, no bubbles
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b0001);
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b0010);
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b0100);
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b1000);
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b0001);
    step_a("rot", 4'b1111, 1'b1, 1'b1, 4'b0010);

    // sticky grant while unacked and requests move elsewhere
    for (int i = 0; i < 5; i++) step_a("hold", 4'b1000, 1'b1, 1'b0, 4'b0010);
    step_a("hold_rel", 4'b1000, 1'b1, 1'b1, 4'b1000);
    step_a("solo_last", 4'b1000, 1'b1, 1'b1, 4'b1000);

    for (int i = 0; i < 3; i++) step_a("solo", 4'b0100, 1'b1, 1'b1, 4'b0100);

    // enable low blocks new grants; ack in IDLE is ignored
    step_a("en_off", 4'b1111, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) step_a("en_off", 4'b1111, 1'b0, 1'b1, 4'b0000);
    step_a("en_on", 4'b1111, 1'b1, 1'b0, 4'b1000);
    step_a("en_hold", 4'b1111, 1'b0, 1'b0, 4'b1000);
    step_a("en_hold", 4'b1111, 1'b1, 1'b0, 4'b1000);
    step_a("req_drop", 4'b0000, 1'b1, 1'b0, 4'b1000);
    step_a("wrap", 4'b1111, 1'b1, 1'b1, 4'b0001);
    step_a("wrap", 4'b1111, 1'b1, 1'b1, 4'b0010);
    step_a("wrap", 4'b1111, 1'b1, 1'b1, 4'b0100);

    // reset mid-grant drops the grant and restores the pointer
    rst_n = 1'b0;
    step_a("rst_mid", 4'b1111, 1'b1, 1'b0, 4'b0000);
    rst_n = 1'b1;
    step_a("rst_ptr", 4'b1111, 1'b1, 1'b1, 4'b0001);

    // rotation toward LSB on the second instance
    step_b("lsb", 4'b1111, 1'b1, 1'b1, 4'b1000);
    step_b("lsb", 4'b1111, 1'b1, 1'b1, 4'b0100);
    step_b("lsb", 4'b1111, 1'b1, 1'b1, 4'b0010);
    step_b("lsb", 4'b1111, 1'b1, 1'b1, 4'b0001);
    step_b("lsb", 4'b1111, 1'b1, 1'b1, 4'b1000);
    if_b.i_req = 4'b0000;

    // random traffic: client 2 always requests and must wait at most W-1 accepted grants
    for (int k = 0; k < 400; k++) begin
      r_req = 4'($urandom) | 4'b0100;
      r_en  = ($urandom_range(0, 3) != 0);
      r_ack = 1'($urandom_range(0, 1));
      if (if_a.o_gnt_vld && r_ack) begin
        if (if_a.o_gnt == 4'b0100) begin
          wait_n = 0;
        end else begin
          wait_n++;
          n_asserts++;
          assert (wait_n <= 3) else begin
            n_fails++;
            $error("FAIL fairness observed wait=%0d expected<=3", wait_n);
          end
        end
      end
      if_a.i_req = r_req;
      if_a.i_en  = r_en;
      if_a.i_ack = r_ack;
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
